// File: rtl/pe_pkg.sv
// Shared types and saturation-limit helpers for the vector dot-product PE.
package pe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } pe_state_e;

    // Widest accumulator the limit helpers can describe.
    localparam int unsigned SAT_LIMIT_W = 128;

    // Largest signed value of a w-bit accumulator, zero-extended to SAT_LIMIT_W.
    function automatic logic [SAT_LIMIT_W-1:0] sat_max(input int unsigned w);
        sat_max = {SAT_LIMIT_W{1'b1}} >> (SAT_LIMIT_W - w + 1);
    endfunction

    // Smallest signed value of a w-bit accumulator; truncate to w bits before use.
    function automatic logic [SAT_LIMIT_W-1:0] sat_min(input int unsigned w);
        sat_min = ~sat_max(w);
    endfunction

endpackage

// File: rtl/pe_vec_if.sv
// Load / start / column-beat / result handshake bundle of the vector PE.
interface pe_vec_if #(
    parameter int unsigned P           = 8,
    parameter int unsigned LANES       = 2,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACCUM_WIDTH = 2 * DATA_WIDTH
);
    logic                                  load_row;
    logic [P-1:0][DATA_WIDTH-1:0]          row;
    logic                                  start;
    logic                                  start_ready;
    logic                                  col_valid;
    logic [LANES-1:0][DATA_WIDTH-1:0]      col_entry;
    logic                                  col_ready;
    logic                                  out_valid;
    logic                                  out_ready;
    logic signed [ACCUM_WIDTH-1:0]         total;
    logic                                  err;

    modport master (
        output load_row, row, start, col_valid, col_entry, out_ready,
        input  start_ready, col_ready, out_valid, total, err
    );

    modport slave (
        input  load_row, row, start, col_valid, col_entry, out_ready,
        output start_ready, col_ready, out_valid, total, err
    );
endinterface

// File: rtl/pe_vec_lane_mac.sv
// LANES-wide multiply, lane-sum tree and overflow-checked accumulate step.
module lane_mac
    import pe_pkg::*;
#(
    parameter int unsigned LANES       = 2,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACCUM_WIDTH = 2 * DATA_WIDTH,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic signed [ACCUM_WIDTH-1:0]      acc,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]   a,
    input  logic [LANES-1:0][DATA_WIDTH-1:0]   b,
    output logic signed [ACCUM_WIDTH-1:0]      acc_next_c,
    output logic                               ovf_c
);
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W  = ACCUM_WIDTH + 1;
    localparam logic signed [ACCUM_WIDTH-1:0] ACC_MAX = ACCUM_WIDTH'(sat_max(ACCUM_WIDTH));
    localparam logic signed [ACCUM_WIDTH-1:0] ACC_MIN = ACCUM_WIDTH'(sat_min(ACCUM_WIDTH));

    logic signed [PROD_W-1:0] prod [LANES];
    logic signed [SUM_W-1:0]  lane_sum;
    logic signed [SUM_W-1:0]  wide;

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            prod[l]  = $signed(a[l]) * $signed(b[l]);
            lane_sum = lane_sum + SUM_W'(prod[l]);
        end
        wide = SUM_W'(acc) + lane_sum;
    end

    // One guard bit above the accumulator: disagreement with the MSB means overflow.
    always_comb begin
        ovf_c      = wide[SUM_W-1] != wide[SUM_W-2];
        acc_next_c = wide[ACCUM_WIDTH-1:0];
        if (SATURATE && ovf_c) begin
            acc_next_c = wide[SUM_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/pe_vec.sv
// Vector dot-product PE: row buffer, beat counter and IDLE/COMPUTE/HOLD control.
module pe_vec
    import pe_pkg::*;
#(
    parameter int unsigned P           = 8,
    parameter int unsigned LANES       = 2,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACCUM_WIDTH = 2 * DATA_WIDTH,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    pe_vec_if.slave    bus
);
    localparam int unsigned K_W = (P > 1) ? $clog2(P) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(P - LANES);
    localparam logic [K_W-1:0] K_STEP = K_W'(LANES);

    pe_state_e                          state;
    logic [K_W-1:0]                     k;
    logic signed [ACCUM_WIDTH-1:0]      acc;
    logic                               err_q;
    logic [P-1:0][DATA_WIDTH-1:0]       row_buf;
    logic                               start_ready_q;
    logic                               col_ready_q;
    logic                               out_valid_q;

    logic [LANES-1:0][DATA_WIDTH-1:0]   row_slice;
    logic signed [ACCUM_WIDTH-1:0]      acc_next_c;
    logic                               ovf_c;

    // Row elements feeding the current beat.
    always_comb begin
        row_slice = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            row_slice[l] = row_buf[k + K_W'(l)];
        end
    end

    lane_mac #(
        .LANES       (LANES),
        .DATA_WIDTH  (DATA_WIDTH),
        .ACCUM_WIDTH (ACCUM_WIDTH),
        .SATURATE    (SATURATE)
    ) u_lane_mac (
        .acc        (acc),
        .a          (row_slice),
        .b          (bus.col_entry),
        .acc_next_c (acc_next_c),
        .ovf_c      (ovf_c)
    );

    // Control FSM; handshake flags are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            k             <= '0;
            acc           <= '0;
            err_q         <= 1'b0;
            row_buf       <= '0;
            start_ready_q <= 1'b1;
            col_ready_q   <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_row) begin
                        row_buf <= bus.row;
                    end
                    if (bus.start) begin
                        state         <= COMPUTE;
                        k             <= '0;
                        acc           <= '0;
                        err_q         <= 1'b0;
                        start_ready_q <= 1'b0;
                        col_ready_q   <= 1'b1;
                    end
                end
                COMPUTE: begin
                    if (bus.col_valid) begin
                        acc   <= acc_next_c;
                        err_q <= err_q | ovf_c;
                        if (k == K_LAST) begin
                            state       <= HOLD;
                            col_ready_q <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            k <= k + K_STEP;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        out_valid_q   <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    start_ready_q <= 1'b1;
                    col_ready_q   <= 1'b0;
                    out_valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.col_ready   = col_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.total       = acc;
    assign bus.err         = err_q;

endmodule
